pipe_load_reader: RTL and testbench

- Read-side companion to the 4-stage ALU/store pipeline, which writes results into the 256x16 data memory.
- Accepts a burst-load request (start address, destination register, length) and issues sequential reads on the synchronous memory read port.
- Returns each word on a valid/ready stream tagged with destination register and address; the stream feeds register-bank write-back or the debug drain path.
- Read data cannot be stalled, so it is held in a credit-managed skid FIFO that absorbs back-pressure.

---
 rtl/pipe_load_reader_pkg.sv | 21 ++
 rtl/pipe_load_reader_if.sv | 32 +++
 rtl/pipe_skid_fifo.sv | 43 ++++
 rtl/pipe_load_reader.sv | 76 +++++++
 tb/tb_pipe_load_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_load_reader_pkg.sv
// Shared widths, FSM encoding and beat tag for the data-memory burst-load path.
package pipe_pkg;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int RW = 4;
   localparam int LW = 4;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [RW-1:0] rd;
      logic          last;
   } tag_t;

   typedef struct packed {
      logic [DW-1:0] data;
      tag_t          tag;
   } beat_t;
endpackage

// File: rtl/pipe_load_reader_if.sv
// Request, memory-read and result-stream signals of the burst-load reader.
interface pipe_load_reader_if;
   import pipe_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [RW-1:0] req_rd;
   logic [LW-1:0] req_len;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [RW-1:0] out_rd;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic          busy;

   modport slave (
      input  req_valid, req_addr, req_rd, req_len, mem_rd_data, out_ready,
      output req_ready, mem_rd_en, mem_rd_addr,
             out_valid, out_data, out_rd, out_addr, out_last, busy
   );

   modport master (
      output req_valid, req_addr, req_rd, req_len, mem_rd_data, out_ready,
      input  req_ready, mem_rd_en, mem_rd_addr,
             out_valid, out_data, out_rd, out_addr, out_last, busy
   );
endinterface

// File: rtl/pipe_skid_fifo.sv
// Small synchronous FIFO holding returned read beats; the writer guarantees room.
module pipe_skid_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic                    do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop = pop && (count != '0);
   assign dout   = mem[rd_ptr];

   // Storage is cleared too, so the head fields read zero out of reset.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(do_pop);
      end
endmodule

// File: rtl/pipe_load_reader.sv
// Burst-load reader: issues sequential memory reads and streams tagged words out.
module pipe_load_reader
   import pipe_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipe_load_reader_if.slave    bus
);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [0:0]    state;
   logic [AW-1:0] cur_addr;
   logic [RW-1:0] cur_rd;
   logic [LW-1:0] remaining;
   logic          inflight;
   tag_t          inflight_tag;
   beat_t         head;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   credit_used;
   logic          issue, pop;

   assign pop = bus.out_valid && bus.out_ready;

   // A beat leaving this cycle frees its slot in time for the read issued now,
   // which is what sustains one beat per cycle with a two-entry FIFO.
   assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue       = (state == ISSUE) && (credit_used < (CW+1)'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= IDLE;
         cur_addr     <= '0;
         cur_rd       <= '0;
         remaining    <= '0;
         inflight     <= 1'b0;
         inflight_tag <= '0;
      end else begin
         inflight <= issue;
         if (issue) inflight_tag <= '{addr: cur_addr, rd: cur_rd, last: (remaining == '0)};
         if (state == IDLE) begin
            if (bus.req_valid) begin
               cur_addr  <= bus.req_addr;
               cur_rd    <= bus.req_rd;
               remaining <= bus.req_len;
               state     <= ISSUE;
            end
         end else if (issue) begin
            cur_addr  <= cur_addr + AW'(1);
            cur_rd    <= cur_rd + RW'(1);
            remaining <= remaining - LW'(1);
            if (remaining == '0) state <= IDLE;
         end
      end

   pipe_skid_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .din   ({bus.mem_rd_data, inflight_tag}),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count)
   );

   assign bus.req_ready   = (state == IDLE);
   assign bus.mem_rd_en   = issue;
   assign bus.mem_rd_addr = cur_addr;
   assign bus.out_valid   = (fifo_count != '0);
   assign bus.out_data    = head.data;
   assign bus.out_rd      = head.tag.rd;
   assign bus.out_addr    = head.tag.addr;
   assign bus.out_last    = head.tag.last;
   assign bus.busy        = (state == ISSUE) || inflight || (fifo_count != '0);
endmodule

// File: tb/tb_pipe_load_reader.sv
// Randomized and directed bench for pipe_load_reader against a burst-level scoreboard.
module tb_pipe_load_reader;
   import pipe_pkg::*;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0, n_err = 0;
   logic [DW-1:0] mem [256];

   pipe_load_reader_if bus();
   pipe_load_reader #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous memory: data one cycle after the strobe, junk otherwise
   always @(posedge clk)
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
      else               bus.mem_rd_data <= 16'($urandom);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: each accepted request expands into its list of beats
   logic [28:0]   exp_q[$];
   logic [28:0]   prev_f;
   logic [AW-1:0] ea;
   logic          stall_prev = 1'b0;
   int            n_beats = 0, n_last = 0, outstanding = 0;
   wire  [28:0]   obs = {bus.out_data, bus.out_rd, bus.out_addr, bus.out_last};

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         outstanding = 0;
         stall_prev  = 1'b0;
      end else begin
         if (bus.req_valid && bus.req_ready)
            for (int i = 0; i <= int'(bus.req_len); i++) begin
               ea = bus.req_addr + AW'(i);
               exp_q.push_back({mem[ea], bus.req_rd + RW'(i), ea, (i == int'(bus.req_len))});
            end
         if (stall_prev) chk("hold", {bus.out_valid, obs}, {1'b1, prev_f});
         if (bus.out_valid && bus.out_ready) begin
            n_beats++;
            if (bus.out_last) n_last++;
            if (exp_q.size() == 0) chk("spurious_beat", 1, 0);
            else                   chk("beat", obs, exp_q.pop_front());
         end
         outstanding = outstanding + int'(bus.mem_rd_en) - int'(bus.out_valid && bus.out_ready);
         if (bus.mem_rd_en) chk("credit", outstanding <= D, 1);
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_f     = obs;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns the cycle number of the accepting edge
   task automatic req(input logic [AW-1:0] a, input logic [RW-1:0] r, input logic [LW-1:0] l,
                      output int acc);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_rd    = r;
      bus.req_len   = l;
      acc = -1;
      for (int i = 0; i < 300 && acc < 0; i++) begin
         @(negedge clk);
         if (bus.req_ready) acc = cyc + 1;
         tick();
      end
      bus.req_valid = 1'b0;
      if (acc < 0) chk("req_timeout", 0, 1);
   endtask

   task automatic drain(input bit rnd_ready);
      int i;
      i = 0;
      while ((bus.busy || exp_q.size() != 0) && i < 600) begin
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         tick();
         i++;
      end
      bus.out_ready = 1'b1;
      if (i >= 600) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2, b0, l0, n, got, gaps, ov;
      logic [LW-1:0] len;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_rd    = '0;
      bus.req_len   = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", {bus.req_ready, bus.mem_rd_en, bus.out_valid, bus.busy}, 4'b1000);
      chk("rst_fields", obs, 0);
      rst_n = 1'b1;
      tick();

      // single beat, latency and busy fall
      mem[8'h10] = 16'hBEEF;
      req(8'h10, 4'd3, 4'd0, acc);
      chk("t1_issue", {bus.mem_rd_en, bus.mem_rd_addr}, {1'b1, 8'h10});
      chk("t1_noreq", {bus.req_ready, bus.out_valid}, 0);
      tick();
      chk("t1_early", {bus.out_valid, bus.mem_rd_en, bus.req_ready}, 3'b001);
      tick();
      chk("t1_beat", {bus.out_valid, obs}, {1'b1, 16'hBEEF, 4'd3, 8'h10, 1'b1});
      chk("t1_lat", cyc - acc, 2);
      tick();
      chk("t1_idle", {bus.out_valid, bus.busy}, 0);

      // address/register wrap
      mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222; mem[8'h00] = 16'h3333; mem[8'h01] = 16'h4444;
      b0 = n_beats; l0 = n_last;
      req(8'hFE, 4'hE, 4'd3, acc);
      drain(1'b0);
      chk("wrap_beats", n_beats - b0, 4);
      chk("wrap_last", n_last - l0, 1);

      // back-pressure
      bus.out_ready = 1'b0;
      b0 = n_beats;
      req(8'h40, 4'd0, 4'd7, acc);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         n += int'(bus.mem_rd_en);
         tick();
      end
      chk("bp_issues", n, D);
      chk("bp_paused", {bus.mem_rd_en, bus.out_valid}, 2'b01);
      bus.out_ready = 1'b1;
      got = 0; gaps = 0;
      for (int i = 0; i < 40 && got < 8; i++) begin
         if (bus.out_valid) got++;
         else gaps++;
         tick();
      end
      chk("bp_got", got, 8);
      chk("bp_gaps", gaps, 0);
      drain(1'b0);
      chk("bp_beats", n_beats - b0, 8);

      // random bursts with random out_ready
      for (int k = 0; k < 5; k++) begin
         len = (k == 0) ? 4'hF : 4'($urandom);
         b0 = n_beats;
         req(8'($urandom), 4'($urandom), len, acc);
         drain(1'b1);
         chk("rnd_beats", n_beats - b0, int'(len) + 1);
      end

      // reset in the middle of a burst
      req(8'h80, 4'd2, 4'd5, acc);
      repeat (4) tick();
      chk("mid_before", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {bus.out_valid, bus.req_ready, bus.mem_rd_en, bus.busy}, 4'b0100);
      chk("mid_fields", obs, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      b0 = n_beats; ov = 0;
      for (int i = 0; i < 6; i++) begin
         ov += int'(bus.out_valid);
         tick();
      end
      chk("mid_quiet", ov, 0);
      mem[8'h20] = 16'($urandom);
      req(8'h20, 4'd7, 4'd0, acc);
      drain(1'b0);
      chk("mid_after", n_beats - b0, 1);

      // back-to-back bursts
      b0 = n_beats; l0 = n_last;
      req(8'h30, 4'd1, 4'd2, acc);
      req(8'h60, 4'd9, 4'd1, acc2);
      chk("b2b_accept", acc2 - acc, 4);
      drain(1'b0);
      chk("b2b_beats", n_beats - b0, 5);
      chk("b2b_last", n_last - l0, 2);
      chk("q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
